// File: rtl/dcache_tag_write_sched.sv
// DCache tag-array write-port scheduler: two-source fixed-priority arbiter with port-1 starvation guard.
// Optional perf counters are compiled in with `define DCACHE_TAGW_SCHED_PERF_EN.
module dcache_tag_write_sched #(
    parameter int WAYS         = 8,
    parameter int ADDR_W       = 36,
    parameter int STARVE_MAX   = 4,
    parameter int WRITE_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_in_0_valid,
    output logic              io_in_0_ready,
    input  logic [WAYS-1:0]   io_in_0_bits_way_en,
    input  logic [ADDR_W-1:0] io_in_0_bits_addr,
    input  logic              io_in_1_valid,
    output logic              io_in_1_ready,
    input  logic [WAYS-1:0]   io_in_1_bits_way_en,
    input  logic [ADDR_W-1:0] io_in_1_bits_addr,
    output logic              io_out_valid,
    input  logic              io_out_ready,
    output logic [WAYS-1:0]   io_out_bits_way_en,
    output logic [ADDR_W-1:0] io_out_bits_addr,
    output logic              io_out_src,
    output logic              io_busy
`ifdef DCACHE_TAGW_SCHED_PERF_EN
    ,
    output logic [15:0]       io_perf_grant0,
    output logic [15:0]       io_perf_grant1,
    output logic [15:0]       io_perf_stall
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RECOVER = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [3:0] REC_LOAD   = 4'(WRITE_CYCLES - 1);

    state_t            state, state_next;
    logic [3:0]        starve_cnt;
    logic [3:0]        rec_cnt;
    logic [WAYS-1:0]   way_en_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic              src_p1;
    logic              grant0, grant1;
    logic              accept;
    logic              out_fire;

    function automatic logic [3:0] starve_inc(input logic [3:0] cnt);
        return (cnt >= STARVE_LIM) ? STARVE_LIM : cnt + 4'd1;
    endfunction

    // Selection: port 0 has priority unless port 1 has been passed over STARVE_MAX times.
    always_comb begin
        grant1 = io_in_1_valid && (!io_in_0_valid || (starve_cnt == STARVE_LIM));
        grant0 = io_in_0_valid && !grant1;
    end

    assign io_in_0_ready = (state == IDLE) && grant0;
    assign io_in_1_ready = (state == IDLE) && grant1;
    assign accept        = io_in_0_ready || io_in_1_ready;
    assign io_out_valid  = (state == ISSUE);
    assign out_fire      = io_out_valid && io_out_ready;
    assign io_busy       = (state != IDLE);

    assign io_out_bits_way_en = way_en_p1;
    assign io_out_bits_addr   = addr_p1;
    assign io_out_src         = src_p1;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = ISSUE;
            end
            ISSUE: begin
                if (io_out_ready) state_next = (WRITE_CYCLES == 1) ? IDLE : RECOVER;
            end
            RECOVER: begin
                if (rec_cnt == 4'd1) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Stage p1: winning request held for the array until its handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
            rec_cnt    <= 4'd0;
            way_en_p1  <= '0;
            addr_p1    <= '0;
            src_p1     <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                way_en_p1 <= grant1 ? io_in_1_bits_way_en : io_in_0_bits_way_en;
                addr_p1   <= grant1 ? io_in_1_bits_addr : io_in_0_bits_addr;
                src_p1    <= grant1;
                if (grant1)
                    starve_cnt <= 4'd0;
                else if (io_in_1_valid)
                    starve_cnt <= starve_inc(starve_cnt);
            end
            if (out_fire && (WRITE_CYCLES > 1))
                rec_cnt <= REC_LOAD;
            else if (state == RECOVER)
                rec_cnt <= rec_cnt - 4'd1;
        end
    end

`ifdef DCACHE_TAGW_SCHED_PERF_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    logic stall;
    assign stall = (io_in_0_valid || io_in_1_valid) && !io_in_0_ready && !io_in_1_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            io_perf_grant0 <= 16'd0;
            io_perf_grant1 <= 16'd0;
            io_perf_stall  <= 16'd0;
        end else begin
            if (io_in_0_ready) io_perf_grant0 <= sat_inc16(io_perf_grant0);
            if (io_in_1_ready) io_perf_grant1 <= sat_inc16(io_perf_grant1);
            if (stall)         io_perf_stall  <= sat_inc16(io_perf_stall);
        end
    end
`endif

endmodule

// File: tb/tb_dcache_tag_write_sched.sv
// Scoreboard bench for dcache_tag_write_sched: directed stimulus pushes expected writes, a monitor pops them.
module tb_dcache_tag_write_sched;

    typedef struct packed {
        logic        src;
        logic [7:0]  way;
        logic [35:0] addr;
    } exp_t;

    localparam logic [7:0]  W0 = 8'h01;
    localparam logic [35:0] A0 = 36'h0_0000_1000;
    localparam logic [7:0]  W1 = 8'h80;
    localparam logic [35:0] A1 = 36'h8_0000_2000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        v0 = 1'b0, v1 = 1'b0, out_ready = 1'b1;
    logic [7:0]  way0 = '0, way1 = '0;
    logic [35:0] addr0 = '0, addr1 = '0;
    logic        rdy0, rdy1, out_valid, out_src, busy;
    logic [7:0]  out_way;
    logic [35:0] out_addr;

    logic        w1_v1 = 1'b0;
    logic [7:0]  w1_way = '0;
    logic [35:0] w1_addr_in = '0;
    logic        w1_rdy0, w1_rdy1, w1_out_valid, w1_src, w1_busy;
    logic [7:0]  w1_out_way;
    logic [35:0] w1_out_addr;

`ifdef DCACHE_TAGW_SCHED_PERF_EN
    logic [15:0] perf_g0, perf_g1, perf_st;
    logic [15:0] w1_perf_g0, w1_perf_g1, w1_perf_st;
`endif

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clock = ~clock;

    dcache_tag_write_sched dut (
        .clock(clock), .reset(reset),
        .io_in_0_valid(v0), .io_in_0_ready(rdy0),
        .io_in_0_bits_way_en(way0), .io_in_0_bits_addr(addr0),
        .io_in_1_valid(v1), .io_in_1_ready(rdy1),
        .io_in_1_bits_way_en(way1), .io_in_1_bits_addr(addr1),
        .io_out_valid(out_valid), .io_out_ready(out_ready),
        .io_out_bits_way_en(out_way), .io_out_bits_addr(out_addr),
        .io_out_src(out_src), .io_busy(busy)
`ifdef DCACHE_TAGW_SCHED_PERF_EN
        , .io_perf_grant0(perf_g0), .io_perf_grant1(perf_g1), .io_perf_stall(perf_st)
`endif
    );

    dcache_tag_write_sched #(.WRITE_CYCLES(1)) dut_w1 (
        .clock(clock), .reset(reset),
        .io_in_0_valid(1'b0), .io_in_0_ready(w1_rdy0),
        .io_in_0_bits_way_en(8'h00), .io_in_0_bits_addr(36'h0),
        .io_in_1_valid(w1_v1), .io_in_1_ready(w1_rdy1),
        .io_in_1_bits_way_en(w1_way), .io_in_1_bits_addr(w1_addr_in),
        .io_out_valid(w1_out_valid), .io_out_ready(out_ready),
        .io_out_bits_way_en(w1_out_way), .io_out_bits_addr(w1_out_addr),
        .io_out_src(w1_src), .io_busy(w1_busy)
`ifdef DCACHE_TAGW_SCHED_PERF_EN
        , .io_perf_grant0(w1_perf_g0), .io_perf_grant1(w1_perf_g1), .io_perf_stall(w1_perf_st)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every array handshake must match the oldest expected write.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual src=%0d way=%0h addr=%0h expected=none",
                         out_src, out_way, out_addr);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_src", 64'(out_src), 64'(mon_e.src));
                chk("sb_way", 64'(out_way), 64'(mon_e.way));
                chk("sb_addr", 64'(out_addr), 64'(mon_e.addr));
            end
        end
    end

    // Both ports held valid; order[i] is the expected winning port of grant i.
    task automatic grant_seq(input int n, input logic [9:0] order);
        int g;
        int last;
        g = 0;
        last = 0;
        for (int i = 0; i < n; i++)
            sb.push_back(order[i] ? exp_t'{1'b1, W1, A1} : exp_t'{1'b0, W0, A0});
        way0 = W0; addr0 = A0; way1 = W1; addr1 = A1;
        v0 = 1'b1; v1 = 1'b1;
        for (int c = 0; c < 60 && g < n; c++) begin
            @(negedge clock);
            if (rdy0 || rdy1) begin
                chk("grant_port", 64'(rdy1), 64'(order[g]));
                chk("grant_exclusive", 64'(rdy0 & rdy1), 64'd0);
                if (g > 0) chk("grant_period", 64'(c - last), 64'd3);
                last = c;
                g++;
            end
            step();
            if (g == n) begin
                v0 = 1'b0;
                v1 = 1'b0;
            end
        end
        v0 = 1'b0;
        v1 = 1'b0;
        chk("grant_count", 64'(g), 64'(n));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) step();
        reset = 1'b0;
        @(negedge clock);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_src", 64'(out_src), 64'd0);
        chk("rst_way", 64'(out_way), 64'd0);
        chk("rst_addr", 64'(out_addr), 64'd0);
        chk("rst_rdy", 64'({rdy0, rdy1}), 64'd0);

        // Single port-0 write: accept at 0, issue at 1, busy 1..2, idle at 3
        step();
        v0 = 1'b1; way0 = 8'h04; addr0 = 36'h1_0000_0040;
        sb.push_back(exp_t'{1'b0, 8'h04, 36'h1_0000_0040});
        @(negedge clock);
        chk("t1_rdy0", 64'(rdy0), 64'd1);
        chk("t1_rdy1", 64'(rdy1), 64'd0);
        chk("t1_busy0", 64'(busy), 64'd0);
        step();
        v0 = 1'b0;
        @(negedge clock);
        chk("t1_out_valid1", 64'(out_valid), 64'd1);
        chk("t1_busy1", 64'(busy), 64'd1);
        step();
        @(negedge clock);
        chk("t1_busy2", 64'(busy), 64'd1);
        chk("t1_out_valid2", 64'(out_valid), 64'd0);
        step();
        @(negedge clock);
        chk("t1_busy3", 64'(busy), 64'd0);
        step();

        // Starvation guard: 0,0,0,0,1,0,0,0,0,1 every 3 cycles
        grant_seq(10, 10'b10_0001_0000);
        repeat (3) step();

        // Backpressure: request held 5 cycles, other requests blocked
        out_ready = 1'b0;
        v0 = 1'b1; way0 = 8'h10; addr0 = 36'h0_ABCD_1230;
        sb.push_back(exp_t'{1'b0, 8'h10, 36'h0_ABCD_1230});
        @(negedge clock);
        chk("t3_rdy0", 64'(rdy0), 64'd1);
        step();
        way0 = 8'hFF; addr0 = 36'hF_FFFF_FFF0;
        v1 = 1'b1; way1 = 8'h55; addr1 = 36'h5_5555_5550;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("t3_hold_valid", 64'(out_valid), 64'd1);
            chk("t3_hold_way", 64'(out_way), 64'h10);
            chk("t3_hold_addr", 64'(out_addr), 64'h0_ABCD_1230);
            chk("t3_hold_src", 64'(out_src), 64'd0);
            chk("t3_hold_rdy", 64'({rdy0, rdy1}), 64'd0);
            step();
        end
        out_ready = 1'b1;
        v0 = 1'b0; v1 = 1'b0;
        @(negedge clock);
        chk("t3_fire_valid", 64'(out_valid), 64'd1);
        repeat (3) step();

`ifdef DCACHE_TAGW_SCHED_PERF_EN
        chk("perf_grant0", 64'(perf_g0), 64'd10);
        chk("perf_grant1", 64'(perf_g1), 64'd2);
        chk("perf_stall", 64'(perf_st), 64'd23);
`endif

        // Reset during ISSUE discards the request and clears starve_cnt
        out_ready = 1'b0;
        way0 = W0; addr0 = A0; way1 = W1; addr1 = A1;
        v0 = 1'b1; v1 = 1'b1;
        @(negedge clock);
        chk("t4_rdy0", 64'(rdy0), 64'd1);
        step();
        reset = 1'b1;
        v0 = 1'b0; v1 = 1'b0;
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("t4_out_valid", 64'(out_valid), 64'd0);
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_way", 64'(out_way), 64'd0);
        chk("t4_addr", 64'(out_addr), 64'd0);
`ifdef DCACHE_TAGW_SCHED_PERF_EN
        chk("t4_perf_clear", 64'({perf_g0, perf_g1, perf_st}), 64'd0);
`endif
        out_ready = 1'b1;
        step();
        grant_seq(5, 10'b00_0001_0000);
        repeat (3) step();

        // WRITE_CYCLES=1: accept every 2 cycles, no RECOVER
        w1_v1 = 1'b1; w1_way = 8'h20; w1_addr_in = 36'h2_0000_0100;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            chk("w1_rdy1", 64'(w1_rdy1), 64'((k % 2) == 0));
            chk("w1_busy", 64'(w1_busy), 64'((k % 2) == 1));
            chk("w1_out_valid", 64'(w1_out_valid), 64'((k % 2) == 1));
            if ((k % 2) == 1) begin
                chk("w1_src", 64'(w1_src), 64'd1);
                chk("w1_addr", 64'(w1_out_addr), 64'h2_0000_0100);
            end
            step();
        end
        w1_v1 = 1'b0;
        repeat (3) step();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcache_tag_write_sched.md
# dcache_tag_write_sched

Scheduler for the DCache tag-array write port. It accepts tag-write requests (way_en + physical address) from two sources: port 0 (refill path) and port 1 (probe/replace path). It grants one request at a time using fixed priority with a starvation guard, registers the winner, issues it to the array, and holds the port closed while the array finishes the multi-cycle write.

## Interface
Parameters:
- WAYS, 8: width of way_en (one-hot).
- ADDR_W, 36: physical address width.
- STARVE_MAX, 4: number of consecutive port-0 wins over a waiting port 1 before port 1 is forced to win; range 1..15.
- WRITE_CYCLES, 2: array occupancy in cycles per write, counted from the issue handshake; range 1..8.

Ports:
- clock, input, 1: single clock.
- reset, input, 1: synchronous, active-high.
- io_in_0_valid, input, 1: port-0 request valid.
- io_in_0_ready, output, 1: port-0 accepted this cycle.
- io_in_0_bits_way_en, input, WAYS: port-0 way select.
- io_in_0_bits_addr, input, ADDR_W: port-0 address.
- io_in_1_valid / io_in_1_ready / io_in_1_bits_way_en / io_in_1_bits_addr: same set of signals for port 1.
- io_out_valid, output, 1: registered write request to the array.
- io_out_ready, input, 1: array accepts the request.
- io_out_bits_way_en, output, WAYS: registered way select.
- io_out_bits_addr, output, ADDR_W: registered address.
- io_out_src, output, 1: source of the current request (0 or 1).
- io_busy, output, 1: high whenever the state is not IDLE.

## Operation
- State machine states: IDLE, ISSUE, RECOVER.
- IDLE:
  - Winner selection: port 0 if valid, unless port 1 is valid and starve_cnt == STARVE_MAX, in which case port 1 wins. If only one port is valid, that port wins.
  - io_in_N_ready = 1 only for the winner. It is combinational from the valids and is 0 in every other state.
  - On acceptance: latch way_en, addr and src into the output register, then go to ISSUE.
- ISSUE:
  - io_out_valid = 1, and the output bits are held stable until io_out_ready.
  - On handshake: if WRITE_CYCLES == 1, go to IDLE. Otherwise load rec_cnt = WRITE_CYCLES-1 and go to RECOVER.
- RECOVER:
  - rec_cnt decrements each cycle.
  - When rec_cnt == 1, transition to IDLE on the next edge. RECOVER therefore lasts WRITE_CYCLES-1 cycles.
- starve_cnt (4 bits) updates only on IDLE acceptance:
  - Increment, saturating at STARVE_MAX, when port 0 wins while port 1 is valid.
  - Clear to 0 when port 1 wins.
  - Unchanged when port 0 wins and port 1 is idle.
- way_en is passed through unchecked. A non-one-hot value is forwarded as-is.
- Simultaneous valids in a non-IDLE state: both readys are 0. Requesters hold their requests; nothing is queued internally.

## Timing
- Reset values:
  - state = IDLE.
  - io_out_valid, io_out_bits_*, io_out_src, io_busy, starve_cnt, rec_cnt: all 0.
  - Both in_readys are 1 only if the corresponding valid wins the IDLE selection.
- Reset asserted mid-operation: any latched request is discarded (not issued), and the next cycle is IDLE with all registers at their reset values.
- Latency: accept at cycle N gives io_out_valid at N+1.
- Back-to-back issue period with io_out_ready held at 1 is WRITE_CYCLES+1 cycles (3 with default parameters).
- Backpressure: io_out_ready low stretches ISSUE indefinitely, with no loss of the request or bits.

## Configuration
- Macro: DCACHE_TAGW_SCHED_PERF_EN.
- When defined:
  - Adds outputs io_perf_grant0, io_perf_grant1 and io_perf_stall, each 16 bits.
  - grant0 and grant1 are saturating acceptance counts per port.
  - stall is a saturating count of cycles in which any in_valid is high while io_in_0_ready and io_in_1_ready are both 0.
  - All three reset to 0.
- When undefined: these ports and their registers do not exist, and all other behaviour is identical.

## Test plan
- Reset, then port 0 valid with way_en=0x04, addr=0x1_0000_0040, io_out_ready=1 → in_0_ready at cycle 0; out_valid with the same bits and src=0 at cycle 1; busy for cycles 1–2; IDLE at cycle 3.
- Both ports valid continuously, STARVE_MAX=4, out_ready=1 → grant order 0,0,0,0,1,0,0,0,0,1, with a grant every 3 cycles.
- io_out_ready held low for 5 cycles during ISSUE → out_valid and bits stay stable for all 5 cycles, both readys stay 0, and the handshake completes on the 6th cycle.
- WRITE_CYCLES=1, port 1 valid continuously → accepts every 2 cycles and RECOVER is never entered.
- Reset pulsed during ISSUE (out_ready=0) → next cycle out_valid=0, state is IDLE, starve_cnt=0, and no write is issued.
- With DCACHE_TAGW_SCHED_PERF_EN, run 3 port-0 grants and 2 port-1 grants → grant0=3, grant1=2, and stall equals the count of valid-but-blocked cycles.
